control_sequencer: RTL and testbench

Microcoded control unit for the ASAP-1 CPU. It steps a 5-state microstep counter and decodes the 4-bit opcode from the instruction register. It drives every bus enable and register load, including `eo`/`su` into the ALU. It also latches the ALU's `zf`/`cf` into an internal flags register for conditional jumps.

---
 rtl/control_sequencer_pkg.sv | 56 +++++
 rtl/control_sequencer_if.sv | 35 +++
 rtl/control_sequencer_rom.sv | 52 +++++
 rtl/control_sequencer.sv | 89 ++++++++
 tb/tb_control_sequencer.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the ASAP-1 control unit: opcodes, microsteps and
// control-word bit positions, so the ROM and the CPU top agree.
package asap_pkg;

    localparam int unsigned OP_W   = 4;
    localparam int unsigned STEP_W = 3;
    localparam int unsigned CW_W   = 16;

    localparam logic [OP_W-1:0] OP_NOP = 4'd0;
    localparam logic [OP_W-1:0] OP_LDA = 4'd1;
    localparam logic [OP_W-1:0] OP_ADD = 4'd2;
    localparam logic [OP_W-1:0] OP_SUB = 4'd3;
    localparam logic [OP_W-1:0] OP_STA = 4'd4;
    localparam logic [OP_W-1:0] OP_LDI = 4'd5;
    localparam logic [OP_W-1:0] OP_JMP = 4'd6;
    localparam logic [OP_W-1:0] OP_JC  = 4'd7;
    localparam logic [OP_W-1:0] OP_JZ  = 4'd8;
    localparam logic [OP_W-1:0] OP_OUT = 4'd14;
    localparam logic [OP_W-1:0] OP_HLT = 4'd15;

    localparam logic [STEP_W-1:0] T0 = 3'd0;
    localparam logic [STEP_W-1:0] T1 = 3'd1;
    localparam logic [STEP_W-1:0] T2 = 3'd2;
    localparam logic [STEP_W-1:0] T3 = 3'd3;
    localparam logic [STEP_W-1:0] T4 = 3'd4;

    localparam int unsigned CW_HLT = 15;
    localparam int unsigned CW_MI  = 14;
    localparam int unsigned CW_RI  = 13;
    localparam int unsigned CW_RO  = 12;
    localparam int unsigned CW_II  = 11;
    localparam int unsigned CW_IO  = 10;
    localparam int unsigned CW_AI  = 9;
    localparam int unsigned CW_AO  = 8;
    localparam int unsigned CW_EO  = 7;
    localparam int unsigned CW_SU  = 6;
    localparam int unsigned CW_BI  = 5;
    localparam int unsigned CW_OI  = 4;
    localparam int unsigned CW_CE  = 3;
    localparam int unsigned CW_CO  = 2;
    localparam int unsigned CW_J   = 1;
    localparam int unsigned CW_FI  = 0;

    typedef logic [CW_W-1:0] ctrl_word_t;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } seq_state_e;

    // One-hot control word with only bit idx set
    function automatic ctrl_word_t cw_bit(input int unsigned idx);
        return ctrl_word_t'(1) << idx;
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Opcode/flag inputs and control-line outputs between the sequencer and the CPU datapath.
interface control_sequencer_if;
    import asap_pkg::*;

    logic [OP_W-1:0]   opcode;
    logic              zf;
    logic              cf;
    logic              hlt;
    logic              mi;
    logic              ri;
    logic              ro;
    logic              ii;
    logic              io;
    logic              ai;
    logic              ao;
    logic              eo;
    logic              su;
    logic              bi;
    logic              oi;
    logic              ce;
    logic              co;
    logic              j;
    logic [STEP_W-1:0] step;

    modport master (
        input  opcode, zf, cf,
        output hlt, mi, ri, ro, ii, io, ai, ao, eo, su, bi, oi, ce, co, j, step
    );

    modport slave (
        output opcode, zf, cf,
        input  hlt, mi, ri, ro, ii, io, ai, ao, eo, su, bi, oi, ce, co, j, step
    );

endinterface

// File: rtl/control_sequencer_rom.sv
// Combinational microcode: (opcode, step, latched flags) -> 16-bit control word.
module control_rom
    import asap_pkg::*;
(
    input  logic [OP_W-1:0]   i_opcode,
    input  logic [STEP_W-1:0] i_step,
    input  logic              i_zf,
    input  logic              i_cf,
    output ctrl_word_t        o_cw_c
);

    always_comb begin
        o_cw_c = '0;
        case (i_step)
            T0: o_cw_c = cw_bit(CW_CO) | cw_bit(CW_MI);
            T1: o_cw_c = cw_bit(CW_RO) | cw_bit(CW_II) | cw_bit(CW_CE);
            T2: begin
                case (i_opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA:
                            o_cw_c = cw_bit(CW_IO) | cw_bit(CW_MI);
                    OP_LDI: o_cw_c = cw_bit(CW_IO) | cw_bit(CW_AI);
                    OP_JMP: o_cw_c = cw_bit(CW_IO) | cw_bit(CW_J);
                    OP_JC:  o_cw_c = cw_bit(CW_IO) | (i_cf ? cw_bit(CW_J) : '0);
                    OP_JZ:  o_cw_c = cw_bit(CW_IO) | (i_zf ? cw_bit(CW_J) : '0);
                    OP_OUT: o_cw_c = cw_bit(CW_AO) | cw_bit(CW_OI);
                    OP_HLT: o_cw_c = cw_bit(CW_HLT);
                    default: o_cw_c = '0;
                endcase
            end
            T3: begin
                case (i_opcode)
                    OP_LDA: o_cw_c = cw_bit(CW_RO) | cw_bit(CW_AI);
                    OP_ADD: o_cw_c = cw_bit(CW_RO) | cw_bit(CW_BI);
                    // su asserted a step early so the ALU result settles before eo
                    OP_SUB: o_cw_c = cw_bit(CW_RO) | cw_bit(CW_BI) | cw_bit(CW_SU);
                    OP_STA: o_cw_c = cw_bit(CW_AO) | cw_bit(CW_RI);
                    default: o_cw_c = '0;
                endcase
            end
            T4: begin
                case (i_opcode)
                    OP_ADD: o_cw_c = cw_bit(CW_EO) | cw_bit(CW_AI) | cw_bit(CW_FI);
                    OP_SUB: o_cw_c = cw_bit(CW_EO) | cw_bit(CW_AI) | cw_bit(CW_FI)
                                   | cw_bit(CW_SU);
                    default: o_cw_c = '0;
                endcase
            end
            default: o_cw_c = '0;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// ASAP-1 control unit: microstep counter, halt state and flags register around
// the microcode ROM; control lines are combinational from the registered state.
module control_sequencer
    import asap_pkg::*;
#(
    parameter int unsigned STEPS = 5
) (
    input  logic                clk,
    input  logic                rst,
    control_sequencer_if.master ctrl
);

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

    logic [STEP_W-1:0] r_step;
    logic [STEP_W-1:0] w_step_nxt;
    seq_state_e        r_state;
    seq_state_e        w_state_nxt;
    logic              r_zf;
    logic              r_cf;
    logic              w_zf_nxt;
    logic              w_cf_nxt;
    ctrl_word_t        w_rom_cw;
    ctrl_word_t        w_cw;

    control_rom u_rom (
        .i_opcode (ctrl.opcode),
        .i_step   (r_step),
        .i_zf     (r_zf),
        .i_cf     (r_cf),
        .o_cw_c   (w_rom_cw)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_step  <= T0;
            r_state <= ST_RUN;
            r_zf    <= 1'b0;
            r_cf    <= 1'b0;
        end else begin
            r_step  <= w_step_nxt;
            r_state <= w_state_nxt;
            r_zf    <= w_zf_nxt;
            r_cf    <= w_cf_nxt;
        end
    end

    // Halt freezes the step at T2 and reduces the word to hlt alone
    always_comb begin
        w_step_nxt  = r_step;
        w_state_nxt = r_state;
        w_zf_nxt    = r_zf;
        w_cf_nxt    = r_cf;
        w_cw        = w_rom_cw;
        if (r_state == ST_HALTED) begin
            w_cw = cw_bit(CW_HLT);
        end else begin
            if (w_rom_cw[CW_HLT]) begin
                w_state_nxt = ST_HALTED;
            end else if (r_step == LAST_STEP) begin
                w_step_nxt = T0;
            end else begin
                w_step_nxt = r_step + STEP_W'(1);
            end
            if (w_rom_cw[CW_FI]) begin
                w_zf_nxt = ctrl.zf;
                w_cf_nxt = ctrl.cf;
            end
        end
    end

    assign ctrl.hlt  = w_cw[CW_HLT];
    assign ctrl.mi   = w_cw[CW_MI];
    assign ctrl.ri   = w_cw[CW_RI];
    assign ctrl.ro   = w_cw[CW_RO];
    assign ctrl.ii   = w_cw[CW_II];
    assign ctrl.io   = w_cw[CW_IO];
    assign ctrl.ai   = w_cw[CW_AI];
    assign ctrl.ao   = w_cw[CW_AO];
    assign ctrl.eo   = w_cw[CW_EO];
    assign ctrl.su   = w_cw[CW_SU];
    assign ctrl.bi   = w_cw[CW_BI];
    assign ctrl.oi   = w_cw[CW_OI];
    assign ctrl.ce   = w_cw[CW_CE];
    assign ctrl.co   = w_cw[CW_CO];
    assign ctrl.j    = w_cw[CW_J];
    assign ctrl.step = r_step;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: microcode words per opcode/step,
// flag latching into conditional jumps, halt, reset and the bus invariant.
module tb_control_sequencer;

    localparam logic [14:0] E_HLT = 15'h4000;
    localparam logic [14:0] E_MI  = 15'h2000;
    localparam logic [14:0] E_RI  = 15'h1000;
    localparam logic [14:0] E_RO  = 15'h0800;
    localparam logic [14:0] E_II  = 15'h0400;
    localparam logic [14:0] E_IO  = 15'h0200;
    localparam logic [14:0] E_AI  = 15'h0100;
    localparam logic [14:0] E_AO  = 15'h0080;
    localparam logic [14:0] E_EO  = 15'h0040;
    localparam logic [14:0] E_SU  = 15'h0020;
    localparam logic [14:0] E_BI  = 15'h0010;
    localparam logic [14:0] E_OI  = 15'h0008;
    localparam logic [14:0] E_CE  = 15'h0004;
    localparam logic [14:0] E_CO  = 15'h0002;
    localparam logic [14:0] E_J   = 15'h0001;
    localparam logic [14:0] E_T0  = E_CO | E_MI;
    localparam logic [14:0] E_T1  = E_RO | E_II | E_CE;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    control_sequencer_if u_if ();

    control_sequencer #(.STEPS(5)) u_dut (
        .clk  (clk),
        .rst  (rst),
        .ctrl (u_if.master)
    );

    always #5 clk = ~clk;

    logic [14:0] w_obs;
    logic [4:0]  w_bus;
    assign w_obs = {u_if.hlt, u_if.mi, u_if.ri, u_if.ro, u_if.ii, u_if.io, u_if.ai,
                    u_if.ao, u_if.eo, u_if.su, u_if.bi, u_if.oi, u_if.ce, u_if.co, u_if.j};
    assign w_bus = {u_if.co, u_if.ro, u_if.io, u_if.ao, u_if.eo};

    task automatic test_reset;
        rst = 1'b1; u_if.opcode = 4'd1; u_if.zf = 1'b0; u_if.cf = 1'b0;
        #1 rst = 1'b0;
        #1;
        n_checks++;
        if (u_if.step !== 3'd0) $display("FAIL reset_step: got %0d expected 0", u_if.step);
        else n_pass++;
        n_checks++;
        if (w_obs !== E_T0) $display("FAIL reset_word: got %h expected %h", w_obs, E_T0);
        else n_pass++;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (u_if.step !== 3'd1) $display("FAIL release_step: got %0d expected 1", u_if.step);
        else n_pass++;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++;
        if (w_obs !== (E_RO | E_AI)) $display("FAIL lda_t3_word: got %h expected %h", w_obs, E_RO | E_AI);
        else n_pass++;
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (u_if.step !== 3'd0) $display("FAIL midreset_step: got %0d expected 0", u_if.step);
        else n_pass++;
        n_checks++;
        if (w_obs !== E_T0) $display("FAIL midreset_word: got %h expected %h", w_obs, E_T0);
        else n_pass++;
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_add_flags;
        logic [14:0] exp_add [5];
        logic [14:0] exp_jz  [5];
        logic [14:0] exp_jc  [5];
        exp_add = '{E_T0, E_T1, E_IO | E_MI, E_RO | E_BI, E_EO | E_AI};
        exp_jz  = '{E_T0, E_T1, E_IO | E_J, 15'h0, 15'h0};
        exp_jc  = '{E_T0, E_T1, E_IO, 15'h0, 15'h0};
        u_if.opcode = 4'd2; u_if.zf = 1'b1; u_if.cf = 1'b0;
        for (int s = 0; s < 5; s++) begin
            n_checks++;
            if (w_obs !== exp_add[s]) $display("FAIL add_word T%0d: got %h expected %h", s, w_obs, exp_add[s]);
            else n_pass++;
            n_checks++;
            if (u_if.step !== 3'(s)) $display("FAIL add_step: got %0d expected %0d", u_if.step, s);
            else n_pass++;
            @(posedge clk); #1;
        end
        // Flag inputs flipped: the jumps must use the latched values
        u_if.zf = 1'b0; u_if.cf = 1'b1;
        u_if.opcode = 4'd8;
        for (int s = 0; s < 5; s++) begin
            n_checks++;
            if (w_obs !== exp_jz[s]) $display("FAIL jz_taken_word T%0d: got %h expected %h", s, w_obs, exp_jz[s]);
            else n_pass++;
            @(posedge clk); #1;
        end
        u_if.opcode = 4'd7;
        for (int s = 0; s < 5; s++) begin
            n_checks++;
            if (w_obs !== exp_jc[s]) $display("FAIL jc_not_taken_word T%0d: got %h expected %h", s, w_obs, exp_jc[s]);
            else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sub_flags;
        logic [14:0] exp_sub [5];
        logic [14:0] exp_jc  [5];
        logic [14:0] exp_jz  [5];
        exp_sub = '{E_T0, E_T1, E_IO | E_MI, E_RO | E_BI | E_SU, E_EO | E_AI | E_SU};
        exp_jc  = '{E_T0, E_T1, E_IO | E_J, 15'h0, 15'h0};
        exp_jz  = '{E_T0, E_T1, E_IO, 15'h0, 15'h0};
        u_if.opcode = 4'd3; u_if.zf = 1'b0; u_if.cf = 1'b1;
        for (int s = 0; s < 5; s++) begin
            n_checks++;
            if (w_obs !== exp_sub[s]) $display("FAIL sub_word T%0d: got %h expected %h", s, w_obs, exp_sub[s]);
            else n_pass++;
            @(posedge clk); #1;
        end
        u_if.zf = 1'b1; u_if.cf = 1'b0;
        u_if.opcode = 4'd7;
        for (int s = 0; s < 5; s++) begin
            n_checks++;
            if (w_obs !== exp_jc[s]) $display("FAIL jc_taken_word T%0d: got %h expected %h", s, w_obs, exp_jc[s]);
            else n_pass++;
            @(posedge clk); #1;
        end
        u_if.opcode = 4'd8;
        for (int s = 0; s < 5; s++) begin
            n_checks++;
            if (w_obs !== exp_jz[s]) $display("FAIL jz_not_taken_word T%0d: got %h expected %h", s, w_obs, exp_jz[s]);
            else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0]  ops [6];
        logic [14:0] tbl [6][5];
        ops = '{4'd1, 4'd4, 4'd5, 4'd6, 4'd14, 4'd0};
        tbl = '{'{E_T0, E_T1, E_IO | E_MI, E_RO | E_AI, 15'h0},
                '{E_T0, E_T1, E_IO | E_MI, E_AO | E_RI, 15'h0},
                '{E_T0, E_T1, E_IO | E_AI, 15'h0, 15'h0},
                '{E_T0, E_T1, E_IO | E_J, 15'h0, 15'h0},
                '{E_T0, E_T1, E_AO | E_OI, 15'h0, 15'h0},
                '{E_T0, E_T1, 15'h0, 15'h0, 15'h0}};
        for (int k = 0; k < 6; k++) begin
            u_if.opcode = ops[k];
            for (int s = 0; s < 5; s++) begin
                n_checks++;
                if (w_obs !== tbl[k][s])
                    $display("FAIL b2b_word op%0d T%0d: got %h expected %h", ops[k], s, w_obs, tbl[k][s]);
                else n_pass++;
                n_checks++;
                if (u_if.step !== 3'(s)) $display("FAIL b2b_step op%0d: got %0d expected %0d", ops[k], u_if.step, s);
                else n_pass++;
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_undefined;
        logic [14:0] exp_u [5];
        exp_u = '{E_T0, E_T1, 15'h0, 15'h0, 15'h0};
        u_if.opcode = 4'd11;
        for (int s = 0; s < 5; s++) begin
            n_checks++;
            if (w_obs !== exp_u[s]) $display("FAIL undef_word T%0d: got %h expected %h", s, w_obs, exp_u[s]);
            else n_pass++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (u_if.step !== 3'd0) $display("FAIL undef_wrap: got %0d expected 0", u_if.step);
        else n_pass++;
    endtask

    task automatic test_halt;
        logic [14:0] exp_h [3];
        exp_h = '{E_T0, E_T1, E_HLT};
        u_if.opcode = 4'd15;
        for (int s = 0; s < 3; s++) begin
            n_checks++;
            if (w_obs !== exp_h[s]) $display("FAIL hlt_word T%0d: got %h expected %h", s, w_obs, exp_h[s]);
            else n_pass++;
            @(posedge clk); #1;
        end
        for (int c = 0; c < 20; c++) begin
            n_checks++;
            if (w_obs !== E_HLT || u_if.step !== 3'd2)
                $display("FAIL halted cycle %0d: got word %h step %0d expected %h step 2", c, w_obs, u_if.step, E_HLT);
            else n_pass++;
            @(posedge clk); #1;
        end
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (w_obs !== E_T0 || u_if.step !== 3'd0)
            $display("FAIL halt_reset: got word %h step %0d expected %h step 0", w_obs, u_if.step, E_T0);
        else n_pass++;
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_sweep;
        for (int fc = 0; fc < 4; fc++) begin
            rst = 1'b0;
            #1;
            @(negedge clk); rst = 1'b1;
            u_if.zf = fc[1]; u_if.cf = fc[0];
            for (int k = -1; k < 16; k++) begin
                u_if.opcode = (k < 0) ? 4'd2 : 4'(k);
                for (int s = 0; s < 5; s++) begin
                    n_checks++;
                    if ($countones(w_bus) > 1)
                        $display("FAIL bus_onehot flags%0d op%0d T%0d: got %b expected at most one bit", fc, u_if.opcode, s, w_bus);
                    else n_pass++;
                    n_checks++;
                    if (u_if.step !== ((k == 15 && s > 2) ? 3'd2 : 3'(s)))
                        $display("FAIL sweep_step flags%0d op%0d: got %0d expected %0d", fc, u_if.opcode, u_if.step,
                                 (k == 15 && s > 2) ? 2 : s);
                    else n_pass++;
                    @(posedge clk); #1;
                end
                u_if.zf = ~fc[1]; u_if.cf = ~fc[0];
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_add_flags();
        test_sub_flags();
        test_back_to_back();
        test_undefined();
        test_halt();
        test_sweep();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
